// File: rtl/xs_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xs_bus_pkg
// Description : Shared definitions for the 6809-style bus strobe sequencer:
//               the quadrature phase encoding, the default I/O page value,
//               the bounds of the decoder select field, and a width helper.
// Revision    : 1.0  initial release
// ============================================================================
package xs_bus_pkg;

    // Quadrature bus phases.
    // PH0: E=0 Q=0, PH1: E=0 Q=1, PH2: E=1 Q=1, PH3: E=1 Q=0.
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    // A[15:13] value that selects the I/O page (0x2000-0x3FFF).
    localparam logic [2:0] c_IO_PAGE_DEFAULT = 3'b001;

    // Address bits forwarded to the decoder select inputs.
    localparam int c_SEL_HI = 12;
    localparam int c_SEL_LO = 11;

    // Counter width for a modulo-n counter, never less than one bit.
    function automatic int width_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xs_phase_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : xs_phase_prescaler
// Description : Modulo-DIV counter that paces the quadrature phases. It
//               flags the last clk of each phase slot and, unless held,
//               issues the phase-advance strobe on that clk.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               i_hold  - suppresses the advance strobe (E stretch)
//               o_tc    - high on the last clk of each DIV-clk slot
//               o_adv   - o_tc qualified by ~i_hold
// Revision    : 1.0  initial release
// ============================================================================
module xs_phase_prescaler
    import xs_bus_pkg::*;
#(
    parameter int DIV = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_hold,
    output logic o_tc,
    output logic o_adv
);

    localparam int              c_W    = width_min1(DIV);
    localparam logic [c_W-1:0]  c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_count;

    // The counter free-runs; holding only withholds the advance strobe so
    // a stretch slot is exactly DIV clks long, same as a normal phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_W'(1);
        end
    end

    assign o_tc  = (r_count == c_LAST);
    assign o_adv = o_tc & ~i_hold;

endmodule
`default_nettype wire

// File: rtl/xs_bus_strobe_seq.sv
`default_nettype none
// ============================================================================
// Module      : xs_bus_strobe_seq
// Description : Generates the 6809-style quadrature bus clocks Q and E from
//               clk, latches the decoder select bits and the I/O-page hit at
//               Q rise, and enables the downstream 2-to-4 decoder only while
//               E is high during a valid I/O-page access.
//               Build option STRETCH_EN: PH3 (E high) is extended by DIV
//               clks per MRDY=0 sample, up to WAIT_MAX extensions.
// Ports       : clk        - system clock
//               RESETn     - asynchronous active-low reset
//               A          - CPU address
//               AVALID     - address valid, sampled with A at Q rise
//               MRDY       - active-high ready, sampled on last clk of PH3
//               Q, E       - quadrature bus clocks
//               DEC_EN_bar - decoder enable, active-low
//               DEC_SEL    - decoder select, latched A[12:11]
//               STRETCHING - high during E-stretch extension slots
// Revision    : 1.0  initial release
// ============================================================================
module xs_bus_strobe_seq
    import xs_bus_pkg::*;
#(
    parameter int         DIV      = 3,
    parameter logic [2:0] IO_PAGE  = c_IO_PAGE_DEFAULT,
    parameter int         WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        RESETn,
    input  logic [15:0] A,
    input  logic        AVALID,
    input  logic        MRDY,
    output logic        Q,
    output logic        E,
    output logic        DEC_EN_bar,
    output logic [1:0]  DEC_SEL,
    output logic        STRETCHING
);

    phase_t     r_phase;
    phase_t     w_phase_nxt;
    logic       w_tc;
    logic       w_adv;
    logic       w_stretch_req;
    logic       w_latch;
    logic       w_hit_nxt;
    logic       w_q_nxt;
    logic       w_e_nxt;

    logic       r_q;
    logic       r_e;
    logic       r_dec_en_n;
    logic [1:0] r_sel;
    logic       r_hit;

    logic [c_SEL_LO-1:0] w_unused_addr;
    assign w_unused_addr = A[c_SEL_LO-1:0];

    xs_phase_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (RESETn),
        .i_hold (w_stretch_req),
        .o_tc   (w_tc),
        .o_adv  (w_adv)
    );

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_phase <= PH0;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_adv) begin
            case (r_phase)
                PH0:     w_phase_nxt = PH1;
                PH1:     w_phase_nxt = PH2;
                PH2:     w_phase_nxt = PH3;
                PH3:     w_phase_nxt = PH0;
                default: w_phase_nxt = PH0;
            endcase
        end
        w_latch   = w_adv && (r_phase == PH0);
        w_hit_nxt = w_latch ? (AVALID && (A[15:13] == IO_PAGE)) : r_hit;
        w_q_nxt   = (w_phase_nxt == PH1) || (w_phase_nxt == PH2);
        w_e_nxt   = (w_phase_nxt == PH2) || (w_phase_nxt == PH3);
    end

    // ------------------------------------------------------------------
    // Registered outputs and address latch. Outputs are computed from the
    // next phase so E and DEC_EN_bar change on the very same clk edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_q        <= 1'b0;
            r_e        <= 1'b0;
            r_dec_en_n <= 1'b1;
            r_sel      <= 2'b00;
            r_hit      <= 1'b0;
        end else begin
            r_q        <= w_q_nxt;
            r_e        <= w_e_nxt;
            r_dec_en_n <= ~(w_e_nxt & w_hit_nxt);
            r_hit      <= w_hit_nxt;
            // The latch only opens entering PH1, when the enable is off.
            if (w_latch) begin
                r_sel <= A[c_SEL_HI:c_SEL_LO];
            end
        end
    end

    assign Q          = r_q;
    assign E          = r_e;
    assign DEC_EN_bar = r_dec_en_n;
    assign DEC_SEL    = r_sel;

    // ------------------------------------------------------------------
    // E stretch
    // ------------------------------------------------------------------
`ifdef STRETCH_EN
    localparam int                 c_CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(WAIT_MAX);

    logic [c_CNT_W-1:0] r_ext_cnt;
    logic               r_stretching;

    // Only meaningful on the last clk of PH3, where the prescaler would
    // otherwise advance; elsewhere the advance strobe is low anyway.
    assign w_stretch_req = (r_phase == PH3) && !MRDY && (r_ext_cnt < c_WAIT_MAX);

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_ext_cnt    <= '0;
            r_stretching <= 1'b0;
        end else if (w_tc && (r_phase == PH3)) begin
            if (w_stretch_req) begin
                r_ext_cnt    <= r_ext_cnt + c_CNT_W'(1);
                r_stretching <= 1'b1;
            end else begin
                r_ext_cnt    <= '0;
                r_stretching <= 1'b0;
            end
        end
    end

    assign STRETCHING = r_stretching;
`else
    logic w_unused_stretch;
    assign w_unused_stretch = MRDY ^ w_tc ^ (WAIT_MAX > 0);
    assign w_stretch_req    = 1'b0;
    assign STRETCHING       = 1'b0;
`endif

endmodule
`default_nettype wire
